// File: rtl/moving_avg_proc_if.sv
// Sample/result handshake between the SPI ADC front end, the averager and the DAC side.
interface moving_avg_proc_if;
  logic       data_valid;
  logic [9:0] data_in;
  logic [9:0] data_out;
  logic       out_valid;

  modport master (output data_valid, data_in, input data_out, out_valid);
  modport slave  (input data_valid, data_in, output data_out, out_valid);
endinterface

// File: rtl/moving_avg_proc.sv
// Edge-triggered moving-average filter over a 2^LOG2_TAPS sample window.
// Define MAVG_DC_BLOCK_EN to output the high-pass residue (sample - avg + 512, clamped).
module moving_avg_proc #(
  parameter int LOG2_TAPS = 3
) (
  input logic             sysclk,
  input logic             rst,
  moving_avg_proc_if.slave bus
);
  localparam int unsigned TAPS = 1 << LOG2_TAPS;
  localparam int unsigned SW   = 10 + LOG2_TAPS;

  typedef enum logic [1:0] {IDLE, UPDATE, OUTPUT} state_e;

  state_e               state_q, state_d;
  logic                 dv_q, armed_q;
  logic [9:0]           sample_q, sample_d;
  logic [SW-1:0]        sum_q, sum_d, sum_new;
  logic [9:0]           taps_q [TAPS];
  logic [9:0]           taps_d [TAPS];
  logic [LOG2_TAPS-1:0] wptr_q, wptr_d;
  logic [9:0]           dout_q, dout_d;
  logic                 ovld_q, ovld_d;
  logic [9:0]           avg, result;
  logic                 accept;

  // armed_q blocks a level that was already high across reset release
  assign accept  = bus.data_valid & ~dv_q & armed_q;
  assign sum_new = sum_q + SW'(sample_q) - SW'(taps_q[wptr_q]);
  assign avg     = sum_new[SW-1:LOG2_TAPS];

`ifdef MAVG_DC_BLOCK_EN
  logic signed [11:0] hp;
  assign hp = $signed({2'b00, sample_q}) - $signed({2'b00, avg}) + 12'sd512;
  always_comb begin
    if (hp < 12'sd0)         result = '0;
    else if (hp > 12'sd1023) result = '1;
    else                     result = hp[9:0];
  end
`else
  assign result = avg;
`endif

  always_comb begin
    state_d  = state_q;
    sample_d = sample_q;
    sum_d    = sum_q;
    taps_d   = taps_q;
    wptr_d   = wptr_q;
    dout_d   = dout_q;
    ovld_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d  = UPDATE;
          sample_d = bus.data_in;
        end
      end
      UPDATE: begin
        state_d        = OUTPUT;
        sum_d          = sum_new;
        taps_d[wptr_q] = sample_q;
        wptr_d         = wptr_q + LOG2_TAPS'(1);
        dout_d         = result;
        ovld_d         = 1'b1;
      end
      OUTPUT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sysclk) begin
    if (rst) begin
      state_q  <= IDLE;
      dv_q     <= 1'b0;
      armed_q  <= ~bus.data_valid;
      sample_q <= '0;
      sum_q    <= '0;
      for (int unsigned i = 0; i < TAPS; i++) taps_q[i] <= '0;
      wptr_q   <= '0;
      dout_q   <= '0;
      ovld_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      dv_q     <= bus.data_valid;
      armed_q  <= armed_q | ~bus.data_valid;
      sample_q <= sample_d;
      sum_q    <= sum_d;
      taps_q   <= taps_d;
      wptr_q   <= wptr_d;
      dout_q   <= dout_d;
      ovld_q   <= ovld_d;
    end
  end

  assign bus.data_out  = dout_q;
  assign bus.out_valid = ovld_q;
endmodule
